// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx serial transmitter.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Ceiling log2, used to size counters at elaboration time.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_tx_bit_period_ctr.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
module bit_period_ctr
  import piso_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 6000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int unsigned CNT_W = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Next count: clear wins, otherwise wrap at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and per-bit strobe.
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 6000000,
  parameter bit          MSB_FIRST    = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sdo,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sdo_q, sdo_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic             accept;
  logic             period_last;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign accept     = load_valid && (state_q == ST_IDLE);
  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_SHIFT);
  assign sdo        = sdo_q;
  assign bit_strobe = strobe_q;
  assign done       = done_q;

  bit_period_ctr #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_period (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (accept),
    .enable (state_q == ST_SHIFT),
    .last   (period_last)
  );

  // FSM next state, shift register, bit counter and registered outputs.
  // sdo is computed one cycle ahead from the value the shift register is about to hold.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sdo_d     = sdo_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sdo_d = 1'b0;
        if (load_valid) begin
          state_d   = ST_SHIFT;
          shift_d   = load_data;
          bit_cnt_d = '0;
          sdo_d     = first_bit(load_data);
          strobe_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (period_last) begin
          if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
            state_d   = ST_IDLE;
            shift_d   = '0;
            bit_cnt_d = '0;
            sdo_d     = 1'b0;
            done_d    = 1'b1;
          end else begin
            shift_d   = advance(shift_q);
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            sdo_d     = first_bit(advance(shift_q));
            strobe_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      sdo_q     <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      sdo_q     <= sdo_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx (MSB-first, LSB-first and one-cycle-bit variants).
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;

  logic       valid_a, valid_b, valid_c;
  logic [3:0] data_a, data_b, data_c;
  logic       ready_a, ready_b, ready_c;
  logic       sdo_a, sdo_b, sdo_c;
  logic       stb_a, stb_b, stb_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(3), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rstn(rstn), .load_valid(valid_a), .load_ready(ready_a),
    .load_data(data_a), .sdo(sdo_a), .bit_strobe(stb_a), .busy(busy_a), .done(done_a));

  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(3), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rstn(rstn), .load_valid(valid_b), .load_ready(ready_b),
    .load_data(data_b), .sdo(sdo_b), .bit_strobe(stb_b), .busy(busy_b), .done(done_b));

  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rstn(rstn), .load_valid(valid_c), .load_ready(ready_c),
    .load_data(data_c), .sdo(sdo_c), .bit_strobe(stb_c), .busy(busy_c), .done(done_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, c, obs, exp);
    end
  endtask

  // Expected waveforms over cycles T+1..T+13, bit [13-c] is cycle T+c.
  logic [12:0] e_sdo_a, e_sdo_b, e_stb, e_done, e_busy;
  logic [12:0] e_sdo_c, e_stb_c, e_done_c;
  logic [12:0] e_sdo_0110;

  initial begin
    e_sdo_a    = 13'b1110001111110;
    e_sdo_b    = 13'b1111110001110;
    e_stb      = 13'b1001001001000;
    e_done     = 13'b0000000000001;
    e_busy     = 13'b1111111111110;
    e_sdo_c    = 13'b1001000000000;
    e_stb_c    = 13'b1111000000000;
    e_done_c   = 13'b0000100000000;
    e_sdo_0110 = 13'b0001111110000;

    rstn = 1'b0;
    valid_a = 1'b1; data_a = 4'b1011;
    valid_b = 1'b1; data_b = 4'b1011;
    valid_c = 1'b1; data_c = 4'b1001;

    // Reset held with load_valid high: everything quiet and ready.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_sdo", i, sdo_a, 1'b0);
      chk("rst_busy", i, busy_a, 1'b0);
      chk("rst_done", i, done_a, 1'b0);
      chk("rst_stb", i, stb_a, 1'b0);
      chk("rst_ready", i, ready_a, 1'b1);
      chk("rst_busy_c", i, busy_c, 1'b0);
    end

    // First edge with rstn high accepts in all three instances.
    rstn = 1'b1;
    tick();
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      chk("msb_sdo",   c, sdo_a,   e_sdo_a[13-c]);
      chk("msb_stb",   c, stb_a,   e_stb[13-c]);
      chk("msb_done",  c, done_a,  e_done[13-c]);
      chk("msb_ready", c, ready_a, ~e_busy[13-c]);
      chk("lsb_sdo",   c, sdo_b,   e_sdo_b[13-c]);
      chk("lsb_busy",  c, busy_b,  e_busy[13-c]);
      chk("lsb_done",  c, done_b,  e_done[13-c]);
      chk("n1_sdo",    c, sdo_c,   e_sdo_c[13-c]);
      chk("n1_stb",    c, stb_c,   e_stb_c[13-c]);
      chk("n1_done",   c, done_c,  e_done_c[13-c]);
      chk("n1_busy",   c, busy_c,  e_stb_c[13-c]);
      if (c < 13) tick();
    end

    // Back-to-back: load_valid held high, mid-word data pulse of 1111 ignored.
    valid_a = 1'b1; data_a = 4'b0110;
    tick();
    for (int w = 0; w < 2; w++) begin
      for (int c = 1; c <= 13; c++) begin
        chk("b2b_sdo",   c, sdo_a,   e_sdo_0110[13-c]);
        chk("b2b_stb",   c, stb_a,   e_stb[13-c]);
        chk("b2b_done",  c, done_a,  e_done[13-c]);
        chk("b2b_ready", c, ready_a, ~e_busy[13-c]);
        if (w == 0 && c == 4) data_a = 4'b1111;
        if (w == 0 && c == 5) data_a = 4'b0110;
        if (w == 1 && c == 1) begin
          valid_a = 1'b0;
          data_a  = 4'b1111;
        end
        if (!(w == 1 && c == 13)) tick();
      end
    end

    // Reset mid-word: rstn low at edge T+5 aborts with no done pulse.
    valid_a = 1'b1; data_a = 4'b1011;
    tick();
    valid_a = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk("abort_sdo", c, sdo_a, e_sdo_a[13-c]);
      chk("abort_busy", c, busy_a, 1'b1);
      if (c < 5) tick();
    end
    rstn = 1'b0;
    tick();
    chk("abort_sdo0",  6, sdo_a,   1'b0);
    chk("abort_busy0", 6, busy_a,  1'b0);
    chk("abort_ready", 6, ready_a, 1'b1);
    chk("abort_done",  6, done_a,  1'b0);
    rstn = 1'b1;
    for (int c = 7; c <= 18; c++) begin
      tick();
      chk("abort_nodone", c, done_a, 1'b0);
      chk("abort_idle",   c, busy_a, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in, serial-out transmitter.
- Takes a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per bit period on sdo.
- An internal bit-period counter replaces a free-running divided clock, so everything runs on the single system clock with a one-cycle strobe.
- Sits on the send side of the board's serial-in shift register and LED display chain, and is driven from button or debounce logic at 12 MHz.

Parameters:
- WIDTH, 4, number of bits per word.
- CLKS_PER_BIT, 6000000, system clock cycles each bit is held on sdo (0.5 s at 12 MHz). Legal range is at least 1.
- MSB_FIRST, 1, 1 sends load_data[WIDTH-1] first; 0 sends load_data[0] first.

Ports:
- clk  input  1  system clock (12 MHz on board); all logic on its rising edge.
- rstn  input  1  synchronous active-low reset; sampled on the clk rising edge.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block will accept a word this cycle. High only in IDLE.
- load_data  input  WIDTH  word to transmit; sampled only on an accepted load.
- sdo  output  1  serial data out. Registered. 0 when idle.
- bit_strobe  output  1  one-cycle pulse in the first cycle each new bit appears on sdo.
- busy  output  1  high while a word is being shifted out.
- done  output  1  one-cycle pulse when the last bit period ends.

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE, shift register=0, bit counter=0, period counter=0, sdo=0, bit_strobe=0, busy=0, done=0, load_ready=1. Reset mid-word aborts the word immediately: no done pulse, and sdo=0 from the next cycle.
- States:
  - IDLE: load_ready=1, busy=0, sdo=0.
  - SHIFT: load_ready=0, busy=1.
- Accept: load_valid=1 and load_ready=1 at edge T.
  - Capture load_data, set state=SHIFT.
  - Clear bit counter and period counter.
  - At T+1: sdo = first bit and bit_strobe=1.
- Bit timing, with N = CLKS_PER_BIT:
  - Bit k (k=0..WIDTH-1) is on sdo for cycles T+1+k*N through T+(k+1)*N.
  - bit_strobe=1 at T+1+k*N only.
  - Period counter counts 0..N-1. At N-1 it wraps to 0 and the shift register advances by one bit (left if MSB_FIRST, else right, zero-filled).
- Completion: in the cycle after bit WIDTH-1's last held cycle (T+1+WIDTH*N):
  - state=IDLE, done=1 (one cycle), busy=0, sdo=0, load_ready=1, bit_strobe=0.
  - A new load can be accepted in that cycle, so the minimum gap between words is one idle cycle.
- load_valid while busy: ignored, with no effect on the word in flight. load_data changes while busy: ignored.
- N=1: sdo changes every cycle, bit_strobe stays high for WIDTH consecutive cycles, and done comes at T+1+WIDTH.
- Widths:
  - Period counter is clog2(CLKS_PER_BIT) bits, minimum 1.
  - Bit counter is clog2(WIDTH)+1 bits.
  - All counter compares are equality against the terminal value; no overflow is possible.
- done and bit_strobe are never high in the same cycle.

Decomposition:
- Shared package piso_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - a clog2 helper function used for counter widths.
- One sub-module, bit_period_ctr. Inputs: clk, rstn, clear, enable. Output: last (high when count==CLKS_PER_BIT-1). Parameter: CLKS_PER_BIT.
- piso_tx holds the FSM, the shift register and the bit counter.

Test Plan (WIDTH=4, CLKS_PER_BIT=3 unless stated):
- Basic MSB-first: load 4'b1011 accepted at T -> sdo=1 T+1..T+3, 0 T+4..T+6, 1 T+7..T+9, 1 T+10..T+12; bit_strobe at T+1,4,7,10; done=1 only at T+13; load_ready=0 T+1..T+12.
- LSB-first (MSB_FIRST=0): load 4'b1011 -> sdo sequence 1,1,0,1, same timing; busy high T+1..T+12.
- Back-to-back and ignored load: hold load_valid=1 with 4'b0110 throughout -> second accept exactly at T+13, first word's sdo unaffected; a pulse of 4'b1111 mid-word is not transmitted.
- Reset mid-word: rstn=0 at T+5 -> at T+6 sdo=0, busy=0, load_ready=1; no done pulse afterwards.
- CLKS_PER_BIT=1: load 4'b1001 at T -> sdo 1,0,0,1 at T+1..T+4, bit_strobe high T+1..T+4, done at T+5.
- Reset state: hold rstn=0 for 3 cycles with load_valid=1 -> sdo=0, busy=0, done=0, bit_strobe=0 throughout; first accept on the first edge with rstn=1.
